irq_controller_param: RTL

Parametrised interrupt controller, successor to the fixed 32-source scanner. Captures masked level- or edge-triggered requests into a pending register and selects one source by fixed or round-robin priority. Presents the selected source to the core with a request/acknowledge handshake and auto-disables on acknowledge. Sits between peripheral interrupt lines and the CPU control unit.

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_priority_arbiter.sv | 46 ++++
 rtl/irq_controller_param.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the parametrised interrupt controller.
package irq_pkg;

    // Controller states; the encoding is fixed so firmware-visible debug taps stay stable.
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ENABLED  = 2'd2,
        ST_ASSERT   = 2'd3
    } irq_state_e;

    localparam int IRQ_NUM_DEFAULT      = 32;
    localparam int IRQ_EI_DELAY_DEFAULT = 4;

endpackage

// File: rtl/irq_priority_arbiter.sv
// Single-cycle source selector: lowest index wins, optionally starting the
// search at a rotating pointer and wrapping back to source 0.
module irq_priority_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_NUM_DEFAULT,
    parameter int ROUND_ROBIN = 0,
    parameter int ID_W        = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    localparam int IDX_W = ID_W + 1;

    logic [2*NUM_IRQ-1:0] dbl;
    logic [IDX_W-1:0]     first;

    // Low copy loses the bits below the pointer, high copy supplies the wrap-around.
    always_comb begin
        dbl = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            dbl[i]           = eligible[i] & ((ROUND_ROBIN == 0) || (ID_W'(i) >= rr_ptr));
            dbl[NUM_IRQ + i] = eligible[i];
        end
    end

    // Lowest-set-bit encoder over the doubled vector, folded back into source range.
    always_comb begin
        first = '0;
        for (int i = 2*NUM_IRQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                first = IDX_W'(i);
            end
        end
        valid = |eligible;
        if (first >= IDX_W'(NUM_IRQ)) begin
            id = ID_W'(first - IDX_W'(NUM_IRQ));
        end else begin
            id = ID_W'(first);
        end
    end

endmodule

// File: rtl/irq_controller_param.sv
// Interrupt controller: captures masked level/edge requests into a pending
// register, arms after an enable delay, presents one source to the core and
// auto-disables when the core acknowledges it.
module irq_controller_param
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_NUM_DEFAULT,
    parameter int ID_W        = $clog2(NUM_IRQ),
    parameter int EI_DELAY    = IRQ_EI_DELAY_DEFAULT,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] irq_edge_mode,
    input  logic               enable_interrupts,
    input  logic               disable_interrupts,
    input  logic               irq_ack,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending
);

    // Counter only needs to hold EI_DELAY-1; keep at least one bit so EI_DELAY<=2 still elaborates.
    localparam int CNT_W = (EI_DELAY > 2) ? $clog2(EI_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (EI_DELAY > 0) ? CNT_W'(EI_DELAY - 1) : '0;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_IRQ - 1);

    irq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               irq_out_q, irq_out_d;

    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] eligible;
    logic               arb_valid;
    logic [ID_W-1:0]    arb_id;
    logic               ack_accept;

    // A source masked after capture keeps its pending bit but cannot be selected.
    assign eligible = pending_q & irq_mask;

    irq_priority_arbiter #(
        .NUM_IRQ     (NUM_IRQ),
        .ROUND_ROBIN (ROUND_ROBIN),
        .ID_W        (ID_W)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .valid    (arb_valid),
        .id       (arb_id)
    );

    // Capture new requests every cycle; a fresh set beats the acknowledge clear.
    always_comb begin
        set_vec    = irq_mask & ((irq_edge_mode & irq_in & ~irq_prev_q) |
                                 (~irq_edge_mode & irq_in));
        irq_prev_d = irq_in;
        clr_vec    = '0;
        if (ack_accept) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // Next-state logic; disable overrides enable and acknowledge in every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_id_d   = irq_id_q;
        rr_ptr_d   = rr_ptr_q;
        ack_accept = 1'b0;
        if (disable_interrupts) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (enable_interrupts) begin
                        if (EI_DELAY == 0) begin
                            state_d = ST_ENABLED;
                        end else begin
                            state_d = ST_ARMING;
                            count_d = CNT_LOAD;
                        end
                    end
                end
                ST_ARMING: begin
                    if (count_q == '0) begin
                        state_d = ST_ENABLED;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                ST_ENABLED: begin
                    if (arb_valid) begin
                        irq_id_d = arb_id;
                        state_d  = ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (irq_ack) begin
                        ack_accept = 1'b1;
                        state_d    = ST_DISABLED;
                        if (ROUND_ROBIN != 0) begin
                            rr_ptr_d = (irq_id_q == LAST_ID) ? '0 : irq_id_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
        irq_out_d = (state_d == ST_ASSERT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_DISABLED;
            count_q    <= '0;
            pending_q  <= '0;
            irq_prev_q <= '0;
            rr_ptr_q   <= '0;
            irq_id_q   <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
            rr_ptr_q   <= rr_ptr_d;
            irq_id_q   <= irq_id_d;
            irq_out_q  <= irq_out_d;
        end
    end

    assign irq_out = irq_out_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule
